comp_seq_ctrl: RTL and testbench
================================

Name: comp_seq_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands, 2 bits per cycle, MSB slice first.
- Each cycle reuses a single 2-bit magnitude-compare slice.
- Operands are accepted with a start/busy/done handshake.
- Results follow the comparator convention: s1 = a>b, s2 = a==b, s3 = a<b, one-hot when valid.
- Sits between operand sources and consumers that need multi-bit compares without a full-width comparator.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >=2. Number of slices N = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a compare; sampled only when busy=0
- a  input  WIDTH  operand A; latched on an accepted start
- b  input  WIDTH  operand B; latched on an accepted start
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when a result is registered
- s1  output  1  A > B (registered, held)
- s2  output  1  A == B (registered, held)
- s3  output  1  A < B (registered, held)
- slice_idx  output  $clog2(N) (min 1)  index of the slice currently being compared; 0 when idle

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE; busy=0, done=0, s1=s2=s3=0, slice_idx=0.
  - Internal operand registers, decided flag and partial result are cleared.
  - rst has priority over all other inputs.
- States:
  - IDLE: busy=0. On an edge with start=1: latch a/b, set slice_idx=N-1, clear the decided flag, go to COMPARE. s1..s3 keep their previous values.
  - COMPARE: busy=1. Each edge compares slice A[2i+1:2i] vs B[2i+1:2i], with i=slice_idx.
    - If not yet decided and the slice differs: record gt/lt and set decided. Lower slices can no longer change the result.
    - Finishing edge (slice_idx==0, or early exit per feature): register s1/s2/s3 one-hot, done=1, busy=0, go to IDLE.
    - If never decided, the result is s2=1.
    - Otherwise slice_idx decrements.
- Latency:
  - Start accepted at edge 0 gives done high after edge N, i.e. N cycles. WIDTH=2 takes 1 cycle.
  - With the feature enabled it can be shorter; see below.
- done: high for exactly one cycle. s1..s3 update only on that same edge and are held until the next done.
- Back-to-back: start=1 during the done cycle is accepted at the next edge, since state is already IDLE. No dead cycle is required.
- start while busy=1: ignored. Changes to a/b while busy are ignored because operands are latched.
- Reset mid-compare: returns to IDLE. No done pulse. s1..s3 go to 0.
- Exactly one of s1/s2/s3 is high after any completed compare. All are 0 only between reset and the first done.

Optional Feature:
- Macro: COMP_SEQ_EARLY_EXIT_EN
- Defined: COMPARE finishes on the edge where the first differing slice is found.
  - Latency = k+1 cycles, where k = number of equal slices above the first differing one.
  - Equal operands still take N cycles.
- Undefined: latency is always N cycles regardless of data. Once decided, later slices are stepped but ignored.

Test Plan:
- WIDTH=8, a=8'hA5, b=8'h3C, start pulse:
  - s1=1, s2=0, s3=0, done after 4 cycles.
  - With COMP_SEQ_EARLY_EXIT_EN: done after 1 cycle.
- WIDTH=8, a=b=8'h5A: s2=1, done after 4 cycles in both builds. busy high for exactly 4 cycles.
- WIDTH=8, a=8'h12, b=8'h13: s3=1, done after 4 cycles in both builds (differ in slice 0).
- WIDTH=8, start a=8'hF0 b=8'h0F, then start with a=8'h00 b=8'hFF while busy:
  - Second start is ignored; result is s1=1.
  - Start held high through the done cycle launches a new compare, and busy rises the next cycle.
- WIDTH=8, rst=1 for one edge during the 2nd compare cycle:
  - Next cycle busy=0, s1=s2=s3=0, slice_idx=0. No done pulse follows.
- WIDTH=2, exhaustive over all 16 (a,b) pairs:
  - Each compare takes 1 cycle.
  - s1/s2/s3 match a>b / a==b / a<b and are always one-hot.

Source files
------------

// File: rtl/comp_seq_ctrl_if.sv
// Operand/result bundle for comp_seq_ctrl: start/busy/done handshake, operands, one-hot compare result.
interface comp_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             s1;
  logic             s2;
  logic             s3;
  logic [IW-1:0]    slice_idx;

  modport master (
    output start, a, b,
    input  busy, done, s1, s2, s3, slice_idx
  );

  modport slave (
    input  start, a, b,
    output busy, done, s1, s2, s3, slice_idx
  );
endinterface

// File: rtl/comp_seq_ctrl.sv
// Serial magnitude comparator: one 2-bit slice per cycle, MSB slice first; N=WIDTH/2 cycles per compare.
// Define COMP_SEQ_EARLY_EXIT_EN to finish on the first differing slice instead of always stepping all N.
module comp_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  comp_seq_ctrl_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             decided;
  logic             gt_q;
  logic             lt_q;

  logic [1:0]       sa;
  logic [1:0]       sb;
  logic             nx_gt;
  logic             nx_lt;
  logic             nx_dec;
  logic             finish;

  // Once a higher slice has differed, the lower slices cannot alter the verdict.
  always_comb begin
    sa     = a_q[{bus.slice_idx, 1'b0} +: 2];
    sb     = b_q[{bus.slice_idx, 1'b0} +: 2];
    nx_gt  = decided ? gt_q : (sa > sb);
    nx_lt  = decided ? lt_q : (sa < sb);
    nx_dec = decided | (sa != sb);
`ifdef COMP_SEQ_EARLY_EXIT_EN
    finish = nx_dec || (bus.slice_idx == '0);
`else
    finish = (bus.slice_idx == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      decided       <= 1'b0;
      gt_q          <= 1'b0;
      lt_q          <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.s1        <= 1'b0;
      bus.s2        <= 1'b0;
      bus.s3        <= 1'b0;
      bus.slice_idx <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q           <= bus.a;
            b_q           <= bus.b;
            decided       <= 1'b0;
            gt_q          <= 1'b0;
            lt_q          <= 1'b0;
            bus.slice_idx <= IW'(N - 1);
            bus.busy      <= 1'b1;
            state         <= COMPARE;
          end
        end
        COMPARE: begin
          if (finish) begin
            bus.s1        <= nx_gt;
            bus.s2        <= ~(nx_gt | nx_lt);
            bus.s3        <= nx_lt;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            bus.slice_idx <= '0;
            state         <= IDLE;
          end else begin
            gt_q          <= nx_gt;
            lt_q          <= nx_lt;
            decided       <= nx_dec;
            bus.slice_idx <= bus.slice_idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed bench for comp_seq_ctrl: WIDTH=8 vectors plus an exhaustive WIDTH=2 sweep.
module tb_comp_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comp_seq_ctrl_if #(.WIDTH(8)) if8 ();
  comp_seq_ctrl_if #(.WIDTH(2)) if2 ();

  comp_seq_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  comp_seq_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

`ifdef COMP_SEQ_EARLY_EXIT_EN
  localparam int LAT_MSB_DIFF = 1;
`else
  localparam int LAT_MSB_DIFF = 4;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Launch one WIDTH=8 compare and follow it to done; res is {s1,s2,s3}.
  task automatic cmp8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [2:0] res, input int lat);
    int cyc;
    int busy_cyc;
    if8.a = av; if8.b = bv; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    check({tag, ".busy_up"}, if8.busy, 1);
    check({tag, ".idx_top"}, if8.slice_idx, 3);
    cyc = 0; busy_cyc = 1;
    while (!if8.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (if8.busy) busy_cyc++;
    end
    check({tag, ".lat"}, cyc, lat);
    check({tag, ".busy_cyc"}, busy_cyc, lat);
    check({tag, ".res"}, {if8.s1, if8.s2, if8.s3}, res);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, if8.done, 0);
    check({tag, ".held"}, {if8.s1, if8.s2, if8.s3}, res);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [1:0] x;
    logic [1:0] y;
    logic [2:0] r;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", if8.busy, 0);
    check("rst.done", if8.done, 0);
    check("rst.res", {if8.s1, if8.s2, if8.s3}, 0);
    check("rst.idx", if8.slice_idx, 0);
    check("rst.res2", {if2.s1, if2.s2, if2.s3}, 0);
    rst = 1'b0;

    cmp8("gt_a5_3c", 8'hA5, 8'h3C, 3'b100, LAT_MSB_DIFF);
    cmp8("eq_5a", 8'h5A, 8'h5A, 3'b010, 4);
    cmp8("lt_12_13", 8'h12, 8'h13, 3'b001, 4);
    cmp8("lt_msb", 8'h3F, 8'hC0, 3'b001, LAT_MSB_DIFF);

    // Start while busy is ignored; start held through done launches the next compare.
    if8.a = 8'hF0; if8.b = 8'h0F; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.a = 8'h00; if8.b = 8'hFF;
    cyc = 0;
    while (!if8.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_ign.lat", cyc, LAT_MSB_DIFF);
    check("busy_ign.res", {if8.s1, if8.s2, if8.s3}, 3'b100);
    @(posedge clk); #1;
    if8.start = 1'b0;
    check("b2b.busy", if8.busy, 1);
    check("b2b.idx", if8.slice_idx, 3);
    cyc = 0;
    while (!if8.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b.lat", cyc, LAT_MSB_DIFF);
    check("b2b.res", {if8.s1, if8.s2, if8.s3}, 3'b001);
    @(posedge clk); #1;

    // Reset on the second compare edge of an equal-operand compare.
    if8.a = 8'h66; if8.b = 8'h66; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    @(posedge clk); #1;
    check("midrst.still_busy", if8.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.busy", if8.busy, 0);
    check("midrst.res", {if8.s1, if8.s2, if8.s3}, 0);
    check("midrst.idx", if8.slice_idx, 0);
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if8.done) pulses++;
    end
    check("midrst.no_done", pulses, 0);

    // WIDTH=2 exhaustive: single-cycle compares, result from a small reference model.
    for (int i = 0; i < 16; i++) begin
      x = 2'(i >> 2); y = 2'(i);
      r = {x > y, x == y, x < y};
      if2.a = x; if2.b = y; if2.start = 1'b1;
      @(posedge clk); #1;
      if2.start = 1'b0;
      cyc = 0;
      while (!if2.done && cyc < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("w2[%0d].lat", i), cyc, 1);
      check($sformatf("w2[%0d].res", i), {if2.s1, if2.s2, if2.s3}, r);
      check($sformatf("w2[%0d].onehot", i), $onehot({if2.s1, if2.s2, if2.s3}), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
